collision_scanner: RTL and testbench
====================================

Name: collision_scanner

Overview:
- Parametrised collision checker for the bird/pipe game; sits between the position generators and the game-state/display logic.
- Every TICK_DIV clocks it snapshots the bird and all NUM_PIPES pipe positions, then scans the pipes one per cycle.
- Latches a sticky game-over flag plus the index of the first pipe hit; only restart or reset clears it.

Parameters:
- POS_W, 12, width of every x/y coordinate (unsigned pixels).
- NUM_PIPES, 3, number of pipe channels scanned (≥1).
- HALF_W, 136, horizontal half-extent of the hit window around pipe_x.
- GAP_HALF, 50, vertical half-height of the pipe gap around pipe_y.
- TICK_DIV, 1000000, clocks between check starts; must be > NUM_PIPES+1.
- IDX_W, $clog2(NUM_PIPES+1), width of hit_idx.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous clear of game-over, tick counter and FSM.
- enable  in  1  when low, ticks are ignored (pause); a scan already in progress still completes.
- bird_x  in  POS_W  bird x position.
- bird_y  in  POS_W  bird y position.
- pipe_x  in  NUM_PIPES*POS_W  packed pipe x; pipe k at bits [k*POS_W +: POS_W].
- pipe_y  in  NUM_PIPES*POS_W  packed gap-centre y, same packing.
- is_over  out  1  sticky collision flag.
- hit_idx  out  IDX_W  index of the colliding pipe; valid while is_over=1.
- check_done  out  1  one-cycle pulse when a scan finishes with no hit.
- busy  out  1  high while in SCAN.

Behaviour:
- Reset (rst_n low, async): FSM=IDLE, tick counter=0, is_over=0, hit_idx=0, check_done=0, busy=0, snapshot registers=0.
- Tick counter runs 0..TICK_DIV-1 and wraps. The internal tick is high for one cycle when count==TICK_DIV-1. It counts in every state except during restart.
- FSM states: IDLE, SCAN, OVER.
- IDLE:
  - On tick&&enable, capture bird_x/y and all pipe_x/y into snapshot registers, set idx=0 and go to SCAN.
  - busy rises the cycle after the tick.
- SCAN:
  - Each cycle evaluate pipe[idx] against the snapshot.
  - Hit test uses POS_W+2-bit signed arithmetic so there is no wrap-around: x_hit = (px-HALF_W < bx) && (bx < px+HALF_W); y_out = (by < py-GAP_HALF) || (by > py+GAP_HALF); hit = x_hit && y_out.
  - All comparisons are strict, so boundary values are not hits.
  - On hit: next edge sets is_over=1, hit_idx=idx, state=OVER. The first hit wins; later pipes are not evaluated.
  - On no hit with idx==NUM_PIPES-1: state=IDLE, check_done=1 for one cycle. Otherwise idx++.
  - Ticks arriving during SCAN are ignored.
  - Scan length is NUM_PIPES cycles. Worst-case is_over latency is NUM_PIPES cycles after the tick edge.
- OVER:
  - is_over and hit_idx hold. Ticks are ignored; busy=0.
- restart:
  - Takes priority over everything else. The next edge gives FSM=IDLE, counter=0, is_over=0, hit_idx=0, check_done=0, busy=0.
  - Legal in any state, including mid-scan; a partial scan is discarded.
- Inputs may change freely during SCAN; only snapshot values are used.

Optional Feature:
- Macro: COLLISION_SCANNER_BOUNDS_EN.
- Defined:
  - Adds parameters CEIL_Y (default 0) and FLOOR_Y (default 460).
  - SCAN runs one extra cycle after the last pipe. If snap_by <= CEIL_Y or snap_by >= FLOOR_Y, then is_over=1 and hit_idx=NUM_PIPES.
  - Scan length becomes NUM_PIPES+1.
- Undefined: no bounds check; hit_idx never equals NUM_PIPES.

Decomposition:
- Package collision_pkg holds:
  - the state enum (IDLE, SCAN, OVER);
  - the default geometry constants (HALF_W, GAP_HALF, CEIL_Y, FLOOR_Y);
  - a function returning the signed hit test for one pipe.
- Sub-module tick_divider (parameter TICK_DIV; ports clk, rst_n, clear, tick) generates the periodic tick.

Test Plan (NUM_PIPES=3, POS_W=12, HALF_W=136, GAP_HALF=50, TICK_DIV=8):
- Bird (100,240), pipes x={200,600,900}, y=240 -> no hit; check_done pulses 3 cycles after the tick; is_over stays 0.
- Bird (100,100), pipe1=(150,240), others far away -> is_over=1 at tick+2, hit_idx=1, busy drops, state held across later ticks.
- Pipe0=(50,240), bird (10,0) -> hit with hit_idx=0; no underflow wrap when px<HALF_W.
- Boundaries: bird_x=pipe_x+136 with y far off -> no hit. bird_x=pipe_x+135, bird_y=pipe_y+50 -> no hit. bird_y=pipe_y+51 -> hit.
- While OVER, pulse restart -> is_over=0 and hit_idx=0 next cycle; the next tick comes 8 cycles later. Assert rst_n low mid-scan -> outputs zero immediately, no check_done.
- With COLLISION_SCANNER_BOUNDS_EN: bird (100,470), pipes far away -> is_over=1, hit_idx=3 at tick+4.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types, default geometry and the per-pipe hit test for collision_scanner.
// Optional bounds check is enabled in the top with COLLISION_SCANNER_BOUNDS_EN.
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OVER
    } state_t;

    localparam int DEF_HALF_W   = 136;
    localparam int DEF_GAP_HALF = 50;
    localparam int DEF_CEIL_Y   = 0;
    localparam int DEF_FLOOR_Y  = 460;

    // Signed math keeps px-half_w and py-gap_half from wrapping near zero.
    function automatic logic pipe_hit(
        input int bx,
        input int by,
        input int px,
        input int py,
        input int half_w,
        input int gap_half
    );
        logic x_hit;
        logic y_out;
        x_hit = (px - half_w < bx) && (bx < px + half_w);
        y_out = (by < py - gap_half) || (by > py + gap_half);
        return x_hit && y_out;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Synchronous clear restarts the period from zero.
module tick_divider #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// Snapshots bird/pipe positions each tick and scans one pipe per cycle for a hit.
// Define COLLISION_SCANNER_BOUNDS_EN to add a ceiling/floor check after the last pipe.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int POS_W     = 12,
    parameter int NUM_PIPES = 3,
    parameter int HALF_W    = DEF_HALF_W,
    parameter int GAP_HALF  = DEF_GAP_HALF,
    parameter int TICK_DIV  = 1000000,
`ifdef COLLISION_SCANNER_BOUNDS_EN
    parameter int CEIL_Y    = DEF_CEIL_Y,
    parameter int FLOOR_Y   = DEF_FLOOR_Y,
`endif
    parameter int IDX_W     = $clog2(NUM_PIPES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       restart,
    input  logic                       enable,
    input  logic [POS_W-1:0]           bird_x,
    input  logic [POS_W-1:0]           bird_y,
    input  logic [NUM_PIPES*POS_W-1:0] pipe_x,
    input  logic [NUM_PIPES*POS_W-1:0] pipe_y,
    output logic                       is_over,
    output logic [IDX_W-1:0]           hit_idx,
    output logic                       check_done,
    output logic                       busy
);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic [IDX_W-1:0] hit_idx_nx;
    logic             over_nx;
    logic             done_nx;
    logic             capture;
    logic             tick;

    logic [POS_W-1:0] snap_bx;
    logic [POS_W-1:0] snap_by;
    logic [POS_W-1:0] snap_px [NUM_PIPES];
    logic [POS_W-1:0] snap_py [NUM_PIPES];

    logic [POS_W-1:0] cur_px;
    logic [POS_W-1:0] cur_py;
    logic             cur_hit;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (restart),
        .tick  (tick)
    );

    always_comb begin
        cur_px = '0;
        cur_py = '0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_px = snap_px[k];
                cur_py = snap_py[k];
            end
        end
    end

    assign cur_hit = pipe_hit(int'(snap_bx), int'(snap_by),
                              int'(cur_px), int'(cur_py),
                              HALF_W, GAP_HALF);

`ifdef COLLISION_SCANNER_BOUNDS_EN
    localparam logic [IDX_W-1:0] BOUNDS_IDX = IDX_W'(NUM_PIPES);

    logic oob;

    assign oob = (int'(snap_by) <= CEIL_Y) || (int'(snap_by) >= FLOOR_Y);
`else
    localparam logic [IDX_W-1:0] LAST_PIPE = IDX_W'(NUM_PIPES - 1);
`endif

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        over_nx    = is_over;
        hit_idx_nx = hit_idx;
        done_nx    = 1'b0;
        capture    = 1'b0;
        if (restart) begin
            state_nx   = IDLE;
            idx_nx     = '0;
            over_nx    = 1'b0;
            hit_idx_nx = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tick && enable) begin
                        capture  = 1'b1;
                        idx_nx   = '0;
                        state_nx = SCAN;
                    end
                end
                SCAN: begin
`ifdef COLLISION_SCANNER_BOUNDS_EN
                    if (idx == BOUNDS_IDX) begin
                        if (oob) begin
                            over_nx    = 1'b1;
                            hit_idx_nx = BOUNDS_IDX;
                            state_nx   = OVER;
                        end else begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end
                    end else if (cur_hit) begin
                        over_nx    = 1'b1;
                        hit_idx_nx = idx;
                        state_nx   = OVER;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
`else
                    if (cur_hit) begin
                        over_nx    = 1'b1;
                        hit_idx_nx = idx;
                        state_nx   = OVER;
                    end else if (idx == LAST_PIPE) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
`endif
                end
                OVER: begin
                    state_nx = OVER;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            is_over    <= 1'b0;
            hit_idx    <= '0;
            check_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            is_over    <= over_nx;
            hit_idx    <= hit_idx_nx;
            check_done <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_bx <= '0;
            snap_by <= '0;
            for (int k = 0; k < NUM_PIPES; k++) begin
                snap_px[k] <= '0;
                snap_py[k] <= '0;
            end
        end else if (capture) begin
            snap_bx <= bird_x;
            snap_by <= bird_y;
            for (int k = 0; k < NUM_PIPES; k++) begin
                snap_px[k] <= pipe_x[k*POS_W +: POS_W];
                snap_py[k] <= pipe_y[k*POS_W +: POS_W];
            end
        end
    end

    assign busy = (state == SCAN);

endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner: vector table with scoreboard plus
// hand-written sequences for reset, restart, pause and mid-scan corner cases.
module tb_collision_scanner;

    localparam int POS_W = 12;
    localparam int NP    = 3;
    localparam int TD    = 8;
    localparam int IDX_W = 2;
    localparam int FAR   = 3000;
`ifdef COLLISION_SCANNER_BOUNDS_EN
    localparam int NSCAN = 4;
    localparam bit BND   = 1'b1;
`else
    localparam int NSCAN = 3;
    localparam bit BND   = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    restart = 1'b0;
    logic                    enable = 1'b1;
    logic [POS_W-1:0]        bird_x = '0;
    logic [POS_W-1:0]        bird_y = '0;
    logic [NP*POS_W-1:0]     pipe_x = '0;
    logic [NP*POS_W-1:0]     pipe_y = '0;
    logic                    is_over;
    logic [IDX_W-1:0]        hit_idx;
    logic                    check_done;
    logic                    busy;

    always #5 clk = ~clk;

    collision_scanner #(
        .POS_W     (POS_W),
        .NUM_PIPES (NP),
        .HALF_W    (136),
        .GAP_HALF  (50),
        .TICK_DIV  (TD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .enable     (enable),
        .bird_x     (bird_x),
        .bird_y     (bird_y),
        .pipe_x     (pipe_x),
        .pipe_y     (pipe_y),
        .is_over    (is_over),
        .hit_idx    (hit_idx),
        .check_done (check_done),
        .busy       (busy)
    );

    typedef struct {
        string             name;
        logic [POS_W-1:0]  bx;
        logic [POS_W-1:0]  by;
        logic [NP*POS_W-1:0] px;
        logic [NP*POS_W-1:0] py;
        logic              hit;
        logic [IDX_W-1:0]  idx;
    } vec_t;

    typedef struct {
        string            name;
        logic             hit;
        logic [IDX_W-1:0] idx;
        int               lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int bx, input int by,
                                input int p0x, input int p0y,
                                input int p1x, input int p1y,
                                input int p2x, input int p2y,
                                input logic hit, input int idx);
        vec_t v;
        v.name = nm;
        v.bx   = POS_W'(bx);
        v.by   = POS_W'(by);
        v.px   = {POS_W'(p2x), POS_W'(p1x), POS_W'(p0x)};
        v.py   = {POS_W'(p2y), POS_W'(p1y), POS_W'(p0y)};
        v.hit  = hit;
        v.idx  = IDX_W'(idx);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bird_x = v.bx;
        bird_y = v.by;
        pipe_x = v.px;
        pipe_y = v.py;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cnt;
        logic seen;
        drive(v);
        e.name = v.name;
        e.hit  = v.hit;
        e.idx  = v.idx;
        e.lat  = TD + (v.hit ? int'(v.idx) + 1 : NSCAN);
        sb.push_back(e);
        do_restart();
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            step();
            cnt++;
            if (is_over || check_done) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no result expected one by cycle %0d",
                     e.name, e.lat);
        end else begin
            chk({e.name, "_over"}, 32'(is_over), 32'(e.hit));
            chk({e.name, "_done"}, 32'(check_done), 32'(!e.hit));
            chk({e.name, "_idx"}, 32'(hit_idx), e.hit ? 32'(e.idx) : 32'd0);
            chk({e.name, "_lat"}, 32'(cnt), 32'(e.lat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   cnt;
        logic saw_a;
        logic saw_b;

        vecs.push_back(mk("clear", 100, 240, 200, 240, 600, 240, 900, 240, 0, 0));
        vecs.push_back(mk("pipe1", 100, 100, FAR, 240, 150, 240, FAR, 240, 1, 1));
        vecs.push_back(mk("lowx", 10, 0, 50, 240, FAR, 240, FAR, 240, 1, 0));
        vecs.push_back(mk("xedge_hi", 636, 10, 500, 240, FAR, 240, FAR, 240, 0, 0));
        vecs.push_back(mk("xedge_lo", 364, 10, 500, 240, FAR, 240, FAR, 240, 0, 0));
        vecs.push_back(mk("yedge", 635, 290, 500, 240, FAR, 240, FAR, 240, 0, 0));
        vecs.push_back(mk("ybeyond", 635, 291, 500, 240, FAR, 240, FAR, 240, 1, 0));
        vecs.push_back(mk("pipe2", 100, 10, FAR, 240, FAR, 240, 100, 240, 1, 2));
        vecs.push_back(mk("first", 100, 10, 100, 240, 100, 240, 100, 240, 1, 0));
        vecs.push_back(mk("floor", 100, 470, FAR, 240, FAR, 240, FAR, 240, BND, 3));
        vecs.push_back(mk("floor_eq", 100, 460, FAR, 240, FAR, 240, FAR, 240, BND, 3));
        vecs.push_back(mk("floor_in", 100, 459, FAR, 240, FAR, 240, FAR, 240, 0, 0));
        vecs.push_back(mk("ceil", 100, 0, FAR, 240, FAR, 240, FAR, 240, BND, 3));

        // reset state
        step();
        step();
        chk("rst_over", 32'(is_over), 32'd0);
        chk("rst_idx", 32'(hit_idx), 32'd0);
        chk("rst_done", 32'(check_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // OVER holds through later ticks
        run_vec(vecs[1]);
        saw_a = 1'b0;
        saw_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) saw_a = 1'b1;
            if (check_done || !is_over) saw_b = 1'b1;
        end
        chk("hold_busy", 32'(saw_a), 32'd0);
        chk("hold_over", 32'(saw_b), 32'd0);
        chk("hold_idx", 32'(hit_idx), 32'd1);

        // restart from OVER, next tick TD cycles later
        do_restart();
        chk("rs_over", 32'(is_over), 32'd0);
        chk("rs_idx", 32'(hit_idx), 32'd0);
        for (int i = 1; i < TD; i++) step();
        chk("rs_busy_pre", 32'(busy), 32'd0);
        step();
        chk("rs_busy_tick", 32'(busy), 32'd1);

        // inputs changing mid-scan are ignored
        drive(vecs[0]);
        do_restart();
        for (int i = 0; i < TD; i++) step();
        drive(vecs[8]);
        for (int i = 0; i < NSCAN; i++) step();
        chk("snap_done", 32'(check_done), 32'd1);
        chk("snap_over", 32'(is_over), 32'd0);

        // pause: ticks ignored while enable is low
        drive(vecs[8]);
        enable = 1'b0;
        do_restart();
        saw_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy || is_over) saw_a = 1'b1;
        end
        chk("pause_idle", 32'(saw_a), 32'd0);
        enable = 1'b1;
        cnt = 0;
        while (!is_over && cnt < 20) begin
            step();
            cnt++;
        end
        chk("resume_over", 32'(is_over), 32'd1);
        chk("resume_idx", 32'(hit_idx), 32'd0);

        // async reset mid-scan
        drive(vecs[0]);
        do_restart();
        for (int i = 0; i < TD + 1; i++) step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_over", 32'(is_over), 32'd0);
        chk("arst_idx", 32'(hit_idx), 32'd0);
        saw_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (check_done || busy) saw_a = 1'b1;
        end
        chk("arst_quiet", 32'(saw_a), 32'd0);
        rst_n = 1'b1;
        step();

        // restart mid-scan discards the partial scan
        drive(vecs[7]);
        do_restart();
        for (int i = 0; i < TD + 1; i++) step();
        do_restart();
        chk("rs_mid_busy", 32'(busy), 32'd0);
        saw_a = 1'b0;
        for (int i = 0; i < TD - 2; i++) begin
            step();
            if (is_over || check_done || busy) saw_a = 1'b1;
        end
        chk("rs_mid_quiet", 32'(saw_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
